// File: rtl/axi_write_slave.sv
// AXI write-channel slave: AW requests are queued in a FIFO, each burst's W beats go out on a simple
// memory write port, and one B response is returned per burst in acceptance order.
module axi_write_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW_DEPTH   = 4
) (
  input  logic                    sig_clock,
  input  logic                    sig_reset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = (AW_DEPTH > 1) ? $clog2(AW_DEPTH) : 1;
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } aw_req_t;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  // AW queue
  aw_req_t          fifo_q [AW_DEPTH];
  aw_req_t          fifo_d [AW_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  aw_req_t          head;
  logic             push, pop;

  // Burst context
  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [7:0]            beat_q, beat_d;
  logic                  aw_err_q, aw_err_d;
  logic                  wl_err_q, wl_err_d;
  logic                  last_beat;

  // Registered outputs
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;

  // Gated by reset so the port reads low while reset is held, not just after the first edge.
  assign awready = !sig_reset && (cnt_q != CNT_W'(AW_DEPTH));
  assign push    = awvalid && awready;
  assign pop     = (state_q == S_IDLE) && (cnt_q != '0);
  assign head    = fifo_q[rd_ptr_q];

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    aw_err_d    = aw_err_q;
    wl_err_d    = wl_err_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          id_d     = head.id;
          addr_d   = head.addr;
          len_d    = head.len;
          size_d   = head.size;
          burst_d  = head.burst;
          beat_d   = '0;
          // WRAP and reserved bursts, and beats wider than the bus, are refused
          aw_err_d = head.burst[1] || ((32'd1 << head.size) > 32'(STRB_WIDTH));
          wl_err_d = 1'b0;
          wready_d = 1'b1;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (wvalid && wready_q) begin
          mem_we_d    = !aw_err_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata;
          mem_wstrb_d = wstrb;
          if (burst_q == BURST_INCR) addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
          beat_d = beat_q + 8'd1;
          // A misplaced wlast only poisons the response; the beats are still written.
          if (wlast != last_beat) wl_err_d = 1'b1;
          if (last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (aw_err_q || wl_err_q || (wlast != last_beat)) ? RESP_SLVERR : RESP_OKAY;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sig_clock or posedge sig_reset) begin
    if (sig_reset) begin
      for (int i = 0; i < AW_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      aw_err_q    <= 1'b0;
      wl_err_q    <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      aw_err_q    <= aw_err_d;
      wl_err_q    <= wl_err_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi_write_slave.sv
// Directed bench for axi_write_slave: INCR/FIXED bursts, AW errors, wlast errors, queue ordering, mid-burst reset.
module tb_axi_write_slave;
  logic        sig_clock = 1'b0;
  logic        sig_reset = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  axi_write_slave #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .AW_DEPTH(4)) dut (
    .sig_clock(sig_clock), .sig_reset(sig_reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 sig_clock = ~sig_clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  int         nvec = 0;
  int         nerr = 0;
  wr_t        mq[$];
  logic [5:0] bq[$];
  wr_t        mon_w;

  // Observed memory writes and B handshakes, sampled mid-cycle
  always @(negedge sig_clock) begin
    if (mem_we) begin
      mon_w.a = mem_addr;
      mon_w.d = mem_wdata;
      mon_w.s = mem_wstrb;
      mq.push_back(mon_w);
    end
    if (bvalid && bready) bq.push_back({bid, bresp});
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"}, wready, 0);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_bid"}, bid, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    int t = 0;
    @(negedge sig_clock);
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    while (!awready && t < 200) begin @(negedge sig_clock); t++; end
    if (!awready) begin
      chk("aw_timeout", 0, 1);
      awvalid = 1'b0;
    end else begin
      @(posedge sig_clock);
      #1 awvalid = 1'b0;
    end
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t = 0;
    @(negedge sig_clock);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && t < 200) begin @(negedge sig_clock); t++; end
    if (!wready) begin
      chk("w_timeout", 0, 1);
      wvalid = 1'b0;
    end else begin
      @(posedge sig_clock);
      #1 wvalid = 1'b0;
    end
  endtask

  task automatic wait_b(input int n);
    int t = 0;
    while (bq.size() < n && t < 300) begin @(negedge sig_clock); t++; end
    if (bq.size() < n) chk("b_timeout", bq.size(), n);
  endtask

  task automatic check_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
    logic [5:0] b;
    if (bq.size() == 0) chk({tag, "_missing"}, 0, 1);
    else begin
      b = bq.pop_front();
      chk({tag, "_bid"}, b[5:2], id);
      chk({tag, "_bresp"}, b[1:0], resp);
    end
  endtask

  task automatic check_wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    if (mq.size() == 0) chk({tag, "_missing"}, 0, 1);
    else begin
      w = mq.pop_front();
      chk({tag, "_addr"}, w.a, a);
      chk({tag, "_data"}, w.d, d);
      chk({tag, "_strb"}, w.s, s);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk_reset_outs("rst0");
    #10 sig_reset = 1'b0;
    @(negedge sig_clock);
    chk("rst0_rel_awready", awready, 1);

    // INCR, 4 beats of 4 bytes
    aw_send(4'd3, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'hA000_0000 + i, 4'hF, i == 3);
    wait_b(1);
    check_b("incr", 4'd3, 2'b00);
    chk("incr_nwr", mq.size(), 4);
    for (int i = 0; i < 4; i++) check_wr("incr_wr", 32'h100 + 4 * i, 32'hA000_0000 + i, 4'hF);

    // FIXED, 2 beats, same address
    aw_send(4'd5, 32'h40, 8'd1, 3'd2, 2'b00);
    w_send(32'h1111_2222, 4'h3, 1'b0);
    w_send(32'h3333_4444, 4'hC, 1'b1);
    wait_b(1);
    check_b("fixed", 4'd5, 2'b00);
    chk("fixed_nwr", mq.size(), 2);
    check_wr("fixed_wr0", 32'h40, 32'h1111_2222, 4'h3);
    check_wr("fixed_wr1", 32'h40, 32'h3333_4444, 4'hC);

    // Reserved burst type, then oversize beat: beat consumed, nothing written
    aw_send(4'd6, 32'h80, 8'd0, 3'd2, 2'b11);
    w_send(32'hDEAD_BEEF, 4'hF, 1'b1);
    wait_b(1);
    check_b("rsvd", 4'd6, 2'b10);
    chk("rsvd_nwr", mq.size(), 0);
    aw_send(4'd7, 32'h80, 8'd0, 3'd3, 2'b01);
    w_send(32'hCAFE_F00D, 4'hF, 1'b1);
    wait_b(1);
    check_b("size", 4'd7, 2'b10);
    chk("size_nwr", mq.size(), 0);

    // wlast early on beat 1 of 3, then wlast never set
    aw_send(4'd8, 32'h300, 8'd2, 3'd2, 2'b01);
    w_send(32'h0000_0010, 4'hF, 1'b0);
    w_send(32'h0000_0011, 4'hF, 1'b1);
    w_send(32'h0000_0012, 4'hF, 1'b0);
    wait_b(1);
    check_b("early", 4'd8, 2'b10);
    chk("early_nwr", mq.size(), 3);
    for (int i = 0; i < 3; i++) check_wr("early_wr", 32'h300 + 4 * i, 32'h10 + i, 4'hF);
    aw_send(4'd9, 32'h400, 8'd2, 3'd2, 2'b01);
    for (int i = 0; i < 3; i++) w_send(32'h20 + i, 4'hF, 1'b0);
    wait_b(1);
    check_b("nolast", 4'd9, 2'b10);
    chk("nolast_nwr", mq.size(), 3);
    mq.delete();

    // Queue fill with B stalled: 1 burst in DATA + 4 queued leaves awready low
    bready = 1'b0;
    for (int k = 0; k < 5; k++) aw_send(4'(k + 1), 32'h500 + 32'(16 * k), 8'd0, 3'd2, 2'b01);
    @(negedge sig_clock);
    chk("q_full_awready", awready, 0);
    chk("q_wready", wready, 1);
    bready = 1'b1;
    for (int k = 0; k < 5; k++) w_send(32'h50 + k, 4'hF, 1'b1);
    wait_b(5);
    for (int k = 0; k < 5; k++) check_b("q_order", 4'(k + 1), 2'b00);
    chk("q_nwr", mq.size(), 5);
    check_wr("q_wr0", 32'h500, 32'h50, 4'hF);
    mq.delete();

    // Reset mid-burst with another AW queued behind it
    aw_send(4'd10, 32'h200, 8'd3, 3'd2, 2'b01);
    aw_send(4'd11, 32'h700, 8'd0, 3'd2, 2'b01);
    w_send(32'h77, 4'hF, 1'b0);
    w_send(32'h78, 4'hF, 1'b0);
    @(negedge sig_clock);
    #2 sig_reset = 1'b1;
    #1 chk_reset_outs("rst1");
    @(negedge sig_clock);
    #2 sig_reset = 1'b0;
    @(negedge sig_clock);
    chk("rst1_rel_awready", awready, 1);
    chk("rst1_rel_wready", wready, 0);
    repeat (5) @(negedge sig_clock);
    chk("rst1_discard_wready", wready, 0);
    chk("rst1_no_b", bq.size(), 0);
    mq.delete();
    aw_send(4'd12, 32'h600, 8'd1, 3'd2, 2'b01);
    w_send(32'h9A, 4'h1, 1'b0);
    w_send(32'h9B, 4'h8, 1'b1);
    wait_b(1);
    check_b("post_rst", 4'd12, 2'b00);
    chk("post_rst_nwr", mq.size(), 2);
    check_wr("post_rst_wr0", 32'h600, 32'h9A, 4'h1);
    check_wr("post_rst_wr1", 32'h604, 32'h9B, 4'h8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
